// File: rtl/reproductor_frames_periodico_if.sv
// Avalon-ST sample stream carried out of the frame replayer: valid, data and packet delimiters.
interface reproductor_frames_periodico_if;
    logic               data_out_valid;
    logic signed [31:0] data_out;
    logic               frame_start;
    logic               frame_end;

    modport master (
        output data_out_valid,
        output data_out,
        output frame_start,
        output frame_end
    );

    modport slave (
        input data_out_valid,
        input data_out,
        input frame_start,
        input frame_end
    );
endinterface

// File: rtl/reproductor_frames_periodico.sv
// Replays a host-loaded table of M samples frame after frame on sample_tick,
// for N frames or continuously when N = 0.
module reproductor_frames_periodico #(
    parameter  int unsigned BUF_TAM = 2048,
    localparam int unsigned AW      = $clog2(BUF_TAM)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [15:0]          ptos_x_ciclo,
    input  logic [15:0]          frames_emitir,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [31:0]   wr_data,
    input  logic                 sample_tick,
    reproductor_frames_periodico_if.master st,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frames_emitidos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW:0]        r_m_eff;
    logic [15:0]        r_n;
    logic [AW-1:0]      r_idx;
    logic [15:0]        r_frames;
    logic signed [31:0] r_mem [BUF_TAM];

    logic [AW:0]        w_m_eff_cfg;
    logic               w_start;
    logic               w_emit;
    logic               w_last;
    logic               w_final;

    always_comb begin
        w_state_nxt = r_state;
        w_m_eff_cfg = (32'(ptos_x_ciclo) > BUF_TAM) ? (AW+1)'(BUF_TAM) : (AW+1)'(ptos_x_ciclo);
        w_start     = (r_state == IDLE) && enable && (ptos_x_ciclo != 16'd0);
        w_emit      = (r_state == RUN) && enable && sample_tick;
        w_last      = ({1'b0, r_idx} == (r_m_eff - 1'b1));
        // Last frame_end of a finite run moves to DONE on the same edge that emits it
        w_final     = w_emit && w_last && (r_n != 16'd0) && ((r_frames + 16'd1) == r_n);

        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN: begin
                if (!enable)      w_state_nxt = IDLE;
                else if (w_final) w_state_nxt = DONE;
            end
            DONE:    if (!enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_eff           <= '0;
            r_n               <= '0;
            r_idx             <= '0;
            r_frames          <= '0;
            st.data_out_valid <= 1'b0;
            st.data_out       <= '0;
            st.frame_start    <= 1'b0;
            st.frame_end      <= 1'b0;
        end else begin
            st.data_out_valid <= w_emit;
            st.frame_start    <= w_emit && (r_idx == '0);
            st.frame_end      <= w_emit && w_last;
            if (w_start) begin
                r_m_eff  <= w_m_eff_cfg;
                r_n      <= frames_emitir;
                r_idx    <= '0;
                r_frames <= '0;
            end
            if (w_emit) begin
                st.data_out <= r_mem[r_idx];
                r_idx       <= w_last ? '0 : r_idx + 1'b1;
                if (w_last && (r_frames != '1)) r_frames <= r_frames + 16'd1;
            end
        end
    end

    // Table is never reset; host writes are blocked only while replaying
    always_ff @(posedge clk) begin
        if (wr_en && (r_state != RUN) && (32'(wr_addr) < BUF_TAM)) r_mem[wr_addr] <= wr_data;
    end

    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign frames_emitidos = r_frames;

endmodule

// File: tb/tb_reproductor_frames_periodico.sv
// Scoreboard bench: a sample-position reference model predicts every emitted sample,
// a negedge monitor pops and compares whenever the stream presents a valid.
module tb_reproductor_frames_periodico;

    localparam int TAM = 2048;

    logic               clk;
    logic               reset_n;
    logic               enable;
    logic [15:0]        ptos_x_ciclo;
    logic [15:0]        frames_emitir;
    logic               wr_en;
    logic [10:0]        wr_addr;
    logic signed [31:0] wr_data;
    logic               sample_tick;
    logic               busy;
    logic               done;
    logic [15:0]        frames_emitidos;

    reproductor_frames_periodico_if st_if ();

    reproductor_frames_periodico #(.BUF_TAM(TAM)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .ptos_x_ciclo    (ptos_x_ciclo),
        .frames_emitir   (frames_emitir),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .sample_tick     (sample_tick),
        .st              (st_if.master),
        .busy            (busy),
        .done            (done),
        .frames_emitidos (frames_emitidos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic signed [31:0] d;
        logic               sop;
        logic               eop;
        int                 cyc;
    } exp_t;

    exp_t q[$];

    // Reference model: a global sample position within the run, not an index/frame counter pair
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t            mstate = M_IDLE;
    int                 mm     = 0;
    int                 mn     = 0;
    int                 pos    = 0;
    logic signed [31:0] mtbl [TAM];

    function automatic int mframes();
        if (mm == 0) return 0;
        return (pos / mm > 65535) ? 65535 : pos / mm;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int k;
        if (!reset_n) return;
        case (mstate)
            M_IDLE: begin
                if (wr_en) mtbl[wr_addr] = wr_data;
                if (enable && ptos_x_ciclo != 0) begin
                    mstate = M_RUN;
                    mm     = (ptos_x_ciclo > TAM) ? TAM : int'(ptos_x_ciclo);
                    mn     = int'(frames_emitir);
                    pos    = 0;
                end
            end
            M_RUN: begin
                if (!enable) mstate = M_IDLE;
                else if (sample_tick) begin
                    k = pos % mm;
                    q.push_back('{mtbl[k], k == 0, k == mm - 1, cyc});
                    pos++;
                    if (mn != 0 && pos == mn * mm) mstate = M_DONE;
                end
            end
            M_DONE: begin
                if (wr_en) mtbl[wr_addr] = wr_data;
                if (!enable) mstate = M_IDLE;
            end
            default: mstate = M_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            chk("busy", busy, mstate == M_RUN);
            chk("done", done, mstate == M_DONE);
            chk("frames_emitidos", frames_emitidos, mframes());
            if (st_if.data_out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 required valid=0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("data_out", st_if.data_out, e.d);
                    chk("frame_start", st_if.frame_start, e.sop);
                    chk("frame_end", st_if.frame_end, e.eop);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got valid=0 required valid=1 data=%0h (cycle %0d)", e.d, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drv(input logic en, input logic tk);
        enable      = en;
        sample_tick = tk;
        wr_en       = 1'b0;
        step();
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic en);
        enable      = en;
        sample_tick = 1'b0;
        wr_en       = 1'b1;
        wr_addr     = 11'(a);
        wr_data     = d;
        step();
        wr_en       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, st_if.data_out_valid, 0);
        chk({tag, "_data"}, st_if.data_out, 0);
        chk({tag, "_sop"}, st_if.frame_start, 0);
        chk({tag, "_eop"}, st_if.frame_end, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_frames"}, frames_emitidos, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        ptos_x_ciclo  = '0;
        frames_emitir = '0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        sample_tick   = 1'b0;
        foreach (mtbl[i]) mtbl[i] = '0;

        #23;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: finite run, two frames of four, ticks every cycle
        for (int i = 0; i < 4; i++) wr(i, 32'(i - 4), 1'b0);
        ptos_x_ciclo  = 16'd4;
        frames_emitir = 16'd2;
        drv(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drv(1'b1, 1'b1);
        chk("t1_done", done, 1);
        chk("t1_frames", frames_emitidos, 2);
        drv(1'b0, 1'b0);

        // 2: continuous, sparse ticks
        for (int i = 0; i < 3; i++) wr(i, 32'(i), 1'b0);
        ptos_x_ciclo  = 16'd3;
        frames_emitir = 16'd0;
        drv(1'b1, 1'b0);
        for (int t = 0; t < 10; t++) begin
            drv(1'b1, 1'b1);
            repeat (4) drv(1'b1, 1'b0);
        end
        chk("t2_busy", busy, 1);
        chk("t2_frames", frames_emitidos, 3);
        drv(1'b0, 1'b0);

        // 3: abort mid-frame, tick during the abort edge must be ignored
        for (int i = 0; i < 4; i++) wr(i, $urandom, 1'b0);
        ptos_x_ciclo = 16'd4;
        drv(1'b1, 1'b0);
        drv(1'b1, 1'b1);
        drv(1'b1, 1'b1);
        drv(1'b0, 1'b1);
        chk("t3_busy_after_abort", busy, 0);
        drv(1'b0, 1'b1);
        drv(1'b1, 1'b0);
        repeat (3) drv(1'b1, 1'b1);
        drv(1'b0, 1'b0);

        // 4: writes ignored during RUN, accepted in DONE
        ptos_x_ciclo  = 16'd2;
        frames_emitir = 16'd2;
        drv(1'b1, 1'b0);
        drv(1'b1, 1'b1);
        wr(0, 32'h7FFF_FFFF, 1'b1);
        repeat (3) drv(1'b1, 1'b1);
        chk("t4_done", done, 1);
        wr(0, 32'h7FFF_FFFF, 1'b1);
        drv(1'b0, 1'b0);
        drv(1'b1, 1'b0);
        repeat (2) drv(1'b1, 1'b1);
        drv(1'b0, 1'b0);

        // 5: M = 0 never starts; M above the table depth wraps at the last entry
        ptos_x_ciclo  = 16'd0;
        frames_emitir = 16'd0;
        repeat (5) drv(1'b1, 1'b1);
        chk("t5_m0_busy", busy, 0);
        drv(1'b0, 1'b0);
        for (int i = 0; i < TAM; i++) wr(i, $urandom, 1'b0);
        ptos_x_ciclo = 16'd5000;
        drv(1'b1, 1'b0);
        for (int i = 0; i < TAM + 4; i++) drv(1'b1, 1'b1);
        chk("t5_frames_wrap", frames_emitidos, 1);
        drv(1'b0, 1'b0);

        // 6: asynchronous reset mid-run, table survives
        ptos_x_ciclo = 16'd3;
        drv(1'b1, 1'b0);
        drv(1'b1, 1'b1);
        drv(1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q.delete();
        mstate = M_IDLE;
        pos    = 0;
        drv(1'b0, 1'b0);
        reset_n = 1'b1;
        drv(1'b1, 1'b0);
        repeat (4) drv(1'b1, 1'b1);
        drv(1'b0, 1'b0);

        // Randomized mix of enables, ticks, writes and configurations
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                ptos_x_ciclo  = 16'($urandom_range(0, 6));
                frames_emitir = 16'($urandom_range(0, 3));
            end
            enable      = ($urandom_range(0, 15) != 0);
            sample_tick = ($urandom_range(0, 2) != 0);
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_addr     = 11'($urandom_range(0, 7));
            wr_data     = $urandom;
            step();
        end
        drv(1'b0, 1'b0);
        drv(1'b0, 1'b0);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
